// File: rtl/uart_rx_deframer.sv
// uart_rx_deframer
//   Turns the byte strobes of a UART receiver into framed packets. A frame is
//   SYNC_BYTE, LEN, LEN payload bytes, CSUM, and it is good when the XOR of LEN,
//   every payload byte and CSUM is zero. Good payloads are buffered and then
//   drained on a valid/ready byte stream; bad frames are dropped with a reason.
//
// Ports
//   clk       in   single clock, rising edge
//   rst       in   synchronous active-high reset
//   rx_done   in   byte-complete flag from the UART (may stay high many cycles)
//   rx_data   in   [7:0] received byte, valid while rx_done is high
//   m_data    out  [7:0] payload byte on the output stream
//   m_valid   out  output stream byte valid
//   m_last    out  final payload byte of the packet (qualified by m_valid)
//   m_ready   in   downstream accept
//   pkt_ok    out  one-cycle pulse: packet passed its checksum
//   pkt_err   out  one-cycle pulse: packet (or byte) dropped
//   err_code  out  [1:0] drop reason, held until the next pkt_err
//                  01 bad length, 10 bad checksum, 11 overrun during drain
//   busy      out  high whenever the deframer is not hunting for SYNC_BYTE
module uart_rx_deframer #(
    parameter logic [7:0]  SYNC_BYTE = 8'hA5,
    parameter int unsigned MAX_LEN   = 16
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       rx_done,
    input  logic [7:0] rx_data,
    output logic [7:0] m_data,
    output logic       m_valid,
    output logic       m_last,
    input  logic       m_ready,
    output logic       pkt_ok,
    output logic       pkt_err,
    output logic [1:0] err_code,
    output logic       busy
);

    // Indices must be able to hold MAX_LEN itself; the buffer address only
    // needs enough bits to reach MAX_LEN-1.
    localparam int unsigned IdxW  = $clog2(MAX_LEN + 1);
    localparam int unsigned AddrW = (MAX_LEN > 1) ? $clog2(MAX_LEN) : 1;

    typedef enum logic [2:0] {
        StHunt,
        StLen,
        StPayload,
        StCsum,
        StSend
    } state_e;

    state_e state_q, state_d;

    logic            rx_done_q;
    logic            strobe;
    logic [7:0]      len_q;
    logic [7:0]      csum_q;
    logic [IdxW-1:0] wr_idx_q;
    logic [IdxW-1:0] rd_idx_q;
    logic [IdxW-1:0] last_idx;
    logic [7:0]      buffer [MAX_LEN];

    logic            len_bad;
    logic            csum_good;
    logic            ok_d;
    logic            err_d;
    logic [1:0]      code_d;

    // Rising edge of rx_done: one strobe per byte however long the flag stays high.
    assign strobe    = rx_done & ~rx_done_q;
    assign len_bad   = (rx_data == 8'h00) || (32'(rx_data) > MAX_LEN);
    assign csum_good = ((csum_q ^ rx_data) == 8'h00);
    assign last_idx  = IdxW'(len_q - 8'd1);

    // ------------------------------------------------------------------
    // FSM state register
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= StHunt;
        end else begin
            state_q <= state_d;
        end
    end

    // ------------------------------------------------------------------
    // FSM next-state logic
    // ------------------------------------------------------------------
    always_comb begin
        state_d = state_q;
        case (state_q)
            StHunt: begin
                if (strobe && (rx_data == SYNC_BYTE)) state_d = StLen;
            end
            StLen: begin
                if (strobe) state_d = len_bad ? StHunt : StPayload;
            end
            StPayload: begin
                // SYNC_BYTE here is ordinary payload; no resync mid-frame.
                if (strobe && (wr_idx_q == last_idx)) state_d = StCsum;
            end
            StCsum: begin
                if (strobe) state_d = csum_good ? StSend : StHunt;
            end
            StSend: begin
                if (m_ready && (rd_idx_q == last_idx)) state_d = StHunt;
            end
            default: state_d = StHunt;
        endcase
    end

    // ------------------------------------------------------------------
    // FSM outputs
    // ------------------------------------------------------------------
    always_comb begin
        busy    = (state_q != StHunt);
        m_valid = (state_q == StSend);
        m_data  = m_valid ? buffer[rd_idx_q[AddrW-1:0]] : 8'h00;
        m_last  = m_valid && (rd_idx_q == last_idx);
    end

    // Status pulse decode; registered below so pulses appear one cycle after
    // the strobe, aligned with the first m_valid of a good packet.
    always_comb begin
        ok_d   = 1'b0;
        err_d  = 1'b0;
        code_d = err_code;
        if (strobe) begin
            case (state_q)
                StLen: begin
                    if (len_bad) begin
                        err_d  = 1'b1;
                        code_d = 2'b01;
                    end
                end
                StCsum: begin
                    if (csum_good) begin
                        ok_d = 1'b1;
                    end else begin
                        err_d  = 1'b1;
                        code_d = 2'b10;
                    end
                end
                StSend: begin
                    // Byte arriving while draining is dropped; drain continues.
                    err_d  = 1'b1;
                    code_d = 2'b11;
                end
                default: ;
            endcase
        end
    end

    // ------------------------------------------------------------------
    // Datapath and status registers
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            rx_done_q <= 1'b0;
            len_q     <= 8'h00;
            csum_q    <= 8'h00;
            wr_idx_q  <= '0;
            rd_idx_q  <= '0;
            pkt_ok    <= 1'b0;
            pkt_err   <= 1'b0;
            err_code  <= 2'b00;
        end else begin
            rx_done_q <= rx_done;
            pkt_ok    <= ok_d;
            pkt_err   <= err_d;
            if (err_d) err_code <= code_d;

            case (state_q)
                StLen: begin
                    if (strobe && !len_bad) begin
                        len_q    <= rx_data;
                        csum_q   <= rx_data;
                        wr_idx_q <= '0;
                    end
                end
                StPayload: begin
                    if (strobe) begin
                        csum_q   <= csum_q ^ rx_data;
                        wr_idx_q <= wr_idx_q + 1'b1;
                    end
                end
                StCsum: begin
                    if (strobe && csum_good) rd_idx_q <= '0;
                end
                StSend: begin
                    if (m_ready) rd_idx_q <= rd_idx_q + 1'b1;
                end
                default: ;
            endcase
        end
    end

    // Payload storage; contents are meaningless outside SEND so no reset.
    always_ff @(posedge clk) begin
        if ((state_q == StPayload) && strobe) begin
            buffer[wr_idx_q[AddrW-1:0]] <= rx_data;
        end
    end

endmodule

// File: tb/tb_uart_rx_deframer.sv
module tb_uart_rx_deframer;

    localparam logic [7:0] SYNC = 8'hA5;
    localparam int         MAXL = 16;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       rx_done = 1'b0;
    logic [7:0] rx_data = 8'h00;
    logic [7:0] m_data;
    logic       m_valid;
    logic       m_last;
    logic       m_ready = 1'b1;
    logic       pkt_ok;
    logic       pkt_err;
    logic [1:0] err_code;
    logic       busy;

    uart_rx_deframer #(
        .SYNC_BYTE (SYNC),
        .MAX_LEN   (MAXL)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .rx_done  (rx_done),
        .rx_data  (rx_data),
        .m_data   (m_data),
        .m_valid  (m_valid),
        .m_last   (m_last),
        .m_ready  (m_ready),
        .pkt_ok   (pkt_ok),
        .pkt_err  (pkt_err),
        .err_code (err_code),
        .busy     (busy)
    );

    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;
    int cyc      = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // ---------------- behavioural model (byte-stream level) ----------------
    logic [8:0] exp_q[$];     // {last, data} still to be delivered
    logic [7:0] frame[$];     // bytes collected after a SYNC
    bit         in_frame  = 0;
    bit         prev_done = 0;
    bit         exp_ok    = 0;
    bit         exp_err   = 0;
    logic [1:0] exp_code  = 2'b00;
    bit         armed     = 0;

    // observations of the DUT, used for directed literal checks
    logic [8:0] got[$];
    int         xfer_cyc[$];
    int         n_ok  = 0;
    int         n_err = 0;

    always @(negedge clk) begin
        logic [7:0] b;
        logic [7:0] x;
        bit         sending;
        int         len;
        if (armed) begin
            chk("m_valid", m_valid, exp_q.size() != 0);
            if (exp_q.size() != 0) begin
                chk("m_data", m_data, exp_q[0][7:0]);
                chk("m_last", m_last, exp_q[0][8]);
            end else begin
                chk("m_last_idle", m_last, 0);
            end
            chk("busy", busy, in_frame || (exp_q.size() != 0));
            chk("pkt_ok", pkt_ok, exp_ok);
            chk("pkt_err", pkt_err, exp_err);
            chk("err_code", err_code, exp_code);
            if (m_valid && m_ready) begin
                got.push_back({m_last, m_data});
                xfer_cyc.push_back(cyc);
            end
            if (pkt_ok)  n_ok++;
            if (pkt_err) n_err++;
        end
        if (rst) begin
            exp_q.delete();
            frame.delete();
            in_frame  = 0;
            prev_done = 0;
            exp_ok    = 0;
            exp_err   = 0;
            exp_code  = 2'b00;
            armed     = 1;
        end else begin
            exp_ok  = 0;
            exp_err = 0;
            sending = (exp_q.size() != 0);
            if (rx_done && !prev_done) begin
                b = rx_data;
                if (sending) begin
                    exp_err  = 1;
                    exp_code = 2'b11;
                end else if (!in_frame) begin
                    if (b == SYNC) begin
                        in_frame = 1;
                        frame.delete();
                    end
                end else begin
                    frame.push_back(b);
                    if (frame.size() == 1) begin
                        if (b == 0 || int'(b) > MAXL) begin
                            exp_err  = 1;
                            exp_code = 2'b01;
                            in_frame = 0;
                        end
                    end else if (frame.size() == int'(frame[0]) + 2) begin
                        x = 8'h00;
                        foreach (frame[i]) x = x ^ frame[i];
                        in_frame = 0;
                        len = int'(frame[0]);
                        if (x == 8'h00) begin
                            exp_ok = 1;
                            for (int i = 1; i <= len; i++)
                                exp_q.push_back({(i == len), frame[i]});
                        end else begin
                            exp_err  = 1;
                            exp_code = 2'b10;
                        end
                    end
                end
            end
            if (sending && m_ready) void'(exp_q.pop_front());
            prev_done = rx_done;
        end
    end

    // ---------------- stimulus helpers ----------------
    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #2;
    endtask

    task automatic send_byte(input logic [7:0] b, input int hold);
        rx_data = b;
        rx_done = 1'b1;
        tick(hold);
        rx_done = 1'b0;
        tick(2);
    endtask

    task automatic send_bytes(input logic [7:0] bs[$], input int hold);
        foreach (bs[i]) send_byte(bs[i], hold);
    endtask

    task automatic wait_idle(input int budget);
        int n = 0;
        while ((busy || m_valid) && n < budget) begin
            tick(1);
            n++;
        end
        if (busy || m_valid) begin
            checks++;
            failures++;
            $display("FAIL wait_idle: still busy after %0d cycles, required idle", budget);
        end
    endtask

    task automatic clear_obs();
        got.delete();
        xfer_cyc.delete();
    endtask

    // ---------------- directed scenarios ----------------
    initial begin
        int ok0, err0;
        logic [7:0] s[$];

        // reset
        rst = 1'b1;
        tick(3);
        rst = 1'b0;
        chk("rst_m_valid", m_valid, 0);
        chk("rst_busy", busy, 0);
        chk("rst_m_data", m_data, 8'h00);
        chk("rst_err_code", err_code, 2'b00);
        chk("rst_pulses", {pkt_ok, pkt_err, m_last}, 3'b000);
        tick(2);

        // good frame, ready high
        clear_obs();
        ok0 = n_ok;
        s = '{8'hA5, 8'h03, 8'h11, 8'h22, 8'h33, 8'h03};
        send_bytes(s, 1);
        wait_idle(50);
        chk("good_ok_count", n_ok - ok0, 1);
        chk("good_len", got.size(), 3);
        if (got.size() == 3) begin
            chk("good_b0", got[0], {1'b0, 8'h11});
            chk("good_b1", got[1], {1'b0, 8'h22});
            chk("good_b2", got[2], {1'b1, 8'h33});
            chk("good_consec", xfer_cyc[2] - xfer_cyc[0], 2);
        end
        chk("good_busy_after", busy, 0);

        // bad checksum, then a good frame
        clear_obs();
        err0 = n_err;
        s = '{8'hA5, 8'h02, 8'h10, 8'h20, 8'h31};
        send_bytes(s, 1);
        chk("csum_err_count", n_err - err0, 1);
        chk("csum_err_code", err_code, 2'b10);
        chk("csum_no_data", got.size(), 0);
        ok0 = n_ok;
        s = '{8'hA5, 8'h01, 8'h7E, 8'h7F};
        send_bytes(s, 1);
        wait_idle(50);
        chk("after_err_ok", n_ok - ok0, 1);
        chk("after_err_data", (got.size() == 1) ? got[0] : 9'h1FF, {1'b1, 8'h7E});

        // bad lengths 0 and 17
        err0 = n_err;
        s = '{8'hA5, 8'h00};
        send_bytes(s, 1);
        chk("len0_err", n_err - err0, 1);
        chk("len0_code", err_code, 2'b01);
        chk("len0_hunt", busy, 0);
        tick(2);
        err0 = n_err;
        s = '{8'hA5, 8'h11};
        send_bytes(s, 1);
        chk("len17_err", n_err - err0, 1);
        chk("len17_code", err_code, 2'b01);
        chk("len17_hunt", busy, 0);

        // stall 10 cycles then toggle ready
        clear_obs();
        m_ready = 1'b0;
        s = '{8'hA5, 8'h04, 8'h01, 8'h02, 8'h03, 8'h04, 8'h00};
        send_bytes(s, 1);
        tick(10);
        chk("stall_valid", m_valid, 1);
        chk("stall_data", m_data, 8'h01);
        chk("stall_none_taken", got.size(), 0);
        for (int i = 0; i < 40 && (busy || m_valid); i++) begin
            m_ready = ~m_ready;
            tick(1);
        end
        m_ready = 1'b1;
        wait_idle(20);
        chk("stall_len", got.size(), 4);
        for (int i = 0; i < 4 && i < got.size(); i++)
            chk("stall_order", got[i], {(i == 3), 8'(i + 1)});

        // long rx_done hold with leading noise
        clear_obs();
        ok0 = n_ok;
        err0 = n_err;
        s = '{8'h00, 8'hFF, 8'hA5, 8'h02, 8'hAB, 8'hCD, 8'h64};
        send_bytes(s, 50);
        wait_idle(50);
        chk("hold_ok", n_ok - ok0, 1);
        chk("hold_no_err", n_err - err0, 0);
        chk("hold_len", got.size(), 2);
        if (got.size() == 2) begin
            chk("hold_b0", got[0], {1'b0, 8'hAB});
            chk("hold_b1", got[1], {1'b1, 8'hCD});
        end

        // overrun during SEND
        clear_obs();
        err0 = n_err;
        m_ready = 1'b0;
        s = '{8'hA5, 8'h02, 8'h55, 8'h66, 8'h31};
        send_bytes(s, 1);
        send_byte(8'h99, 1);
        chk("ovr_err", n_err - err0, 1);
        chk("ovr_code", err_code, 2'b11);
        m_ready = 1'b1;
        wait_idle(50);
        chk("ovr_len", got.size(), 2);
        if (got.size() == 2) begin
            chk("ovr_b0", got[0], {1'b0, 8'h55});
            chk("ovr_b1", got[1], {1'b1, 8'h66});
        end

        // reset mid-payload, then a fresh frame
        clear_obs();
        err0 = n_err;
        s = '{8'hA5, 8'h05, 8'h01, 8'h02};
        send_bytes(s, 1);
        chk("mid_busy", busy, 1);
        rst = 1'b1;
        tick(2);
        rst = 1'b0;
        chk("mid_rst_outs", {m_valid, m_last, pkt_ok, pkt_err, busy}, 5'b0);
        chk("mid_rst_data", {m_data, err_code}, 10'h000);
        tick(3);
        chk("mid_no_err", n_err - err0, 0);
        ok0 = n_ok;
        s = '{8'hA5, 8'h01, 8'hC3, 8'hC2};
        send_bytes(s, 1);
        wait_idle(50);
        chk("fresh_ok", n_ok - ok0, 1);
        chk("fresh_data", (got.size() == 1) ? got[0] : 9'h1FF, {1'b1, 8'hC3});

        tick(3);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: simulation did not finish, required finish");
        $fatal(1);
    end

endmodule
